fetch_fifo: RTL and testbench
=============================

FETCH_FIFO -- requirements
Module: fetch_fifo

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, 16, data bits per entry.
REQ-002 Parameter DEPTH SHALL be: DEPTH, 8, number of entries; power of two, minimum 2.
REQ-003 Parameter AF_LEVEL SHALL be: AF_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 Port clk SHALL be: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n SHALL be: rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port flush SHALL be: flush  input  1  discard all entries (branch redirect).
REQ-007 Port push_valid SHALL be: push_valid  input  1  producer offers push_data.
REQ-008 Port push_data SHALL be: push_data  input  WIDTH  entry to enqueue.
REQ-009 Port push_ready SHALL be: push_ready  output  1  FIFO can accept an entry; equals not full.
REQ-010 Port pop_valid SHALL be: pop_valid  output  1  pop_data holds the oldest entry; equals not empty.
REQ-011 Port pop_data SHALL be: pop_data  output  WIDTH  oldest entry, show-ahead.
REQ-012 Port pop_ready SHALL be: pop_ready  input  1  consumer takes pop_data this cycle.
REQ-013 Port count SHALL be: count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 Port almost_full SHALL be: almost_full  output  1  count >= AF_LEVEL.
REQ-015 Port overflow SHALL be: overflow  output  1  sticky: push_valid seen while full.

Function
REQ-016 Storage SHALL be a circular buffer with read pointer, write pointer and occupancy counter; entries never shift.
REQ-017 A push SHALL fire when push_valid and push_ready are both 1 at a clock edge: write mem[wr_ptr], wr_ptr+1 modulo DEPTH.
REQ-018 A pop SHALL fire when pop_valid and pop_ready are both 1 at a clock edge: rd_ptr+1 modulo DEPTH.
REQ-019 count SHALL rise by 1 on push only, fall by 1 on pop only, and hold on push plus pop or neither.
REQ-020 pop_data SHALL equal mem[rd_ptr] combinationally; it is undefined when pop_valid is 0 and a bench SHALL NOT check it then.
REQ-021 The FIFO SHALL have no empty bypass: an entry pushed at edge N drives pop_valid=1 from edge N onward and can pop at edge N+1 at the earliest.
REQ-022 push_ready SHALL depend only on registered state; while full, a push is refused even when a pop fires in the same cycle.
REQ-023 Simultaneous push and pop at non-empty, non-full occupancy SHALL both fire and leave count unchanged.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.
REQ-025 flush=1 at an edge SHALL zero both pointers and count, suppress any push or pop in that cycle, and leave overflow unchanged.
REQ-026 overflow SHALL set at an edge where push_valid=1 and push_ready=0, and SHALL clear only on reset.
REQ-027 A push or pop attempted while refused SHALL NOT change any pointer, count or memory entry.

Reset
REQ-028 rst_n=0 SHALL immediately force pointers=0, count=0, push_ready=1, pop_valid=0, almost_full=0 and overflow=0, independent of clk.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first edge after rst_n rises SHALL behave as from empty.

Structure
REQ-031 Package fetch_pkg SHALL hold FETCH_WIDTH=16 and FETCH_DEPTH=8 as the defaults for WIDTH and DEPTH.
REQ-032 One sub-module, fetch_fifo_mem, SHALL hold the register-array storage: 1 write port, 1 asynchronous read port, no reset.
REQ-033 Pointer, count and flag logic SHALL reside in fetch_fifo.

Verification
REQ-034 Fill then drain: push 0x0001..0x0008 -> push_ready=0 and count=8 after the 8th push; pops return 0x0001..0x0008 in order; pop_valid=0 at end.
REQ-035 Wrap: push 6 entries, pop 6, push 0xA000..0xA005 -> pops return 0xA000..0xA005 in order across the pointer wrap.
REQ-036 Concurrent: at count=4, hold push_valid=pop_ready=1 for 10 cycles -> count stays 4 and output order is preserved.
REQ-037 Full boundary: at count=8, push 0xBEEF with pop_ready=1 -> pop fires, push refused, count=7, overflow=1, 0xBEEF never appears at pop_data.
REQ-038 Flush: at count=5, flush with push_valid=1 -> count=0, pop_valid=0, no entry written; the next push of 0x1234 pops as 0x1234.
REQ-039 Async reset: drop rst_n between edges at count=3 -> count=0, pop_valid=0 and overflow=0 before the next clk edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared defaults for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned FETCH_WIDTH = 16;
  localparam int unsigned FETCH_DEPTH = 8;

endpackage

// File: rtl/fetch_fifo_mem.sv
// Register-array storage for the fetch FIFO: one write port, one asynchronous read port.
module fetch_fifo_mem
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_WIDTH,
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_fifo.sv
// Show-ahead fetch FIFO: circular buffer with occupancy counter, flush and sticky overflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH    = FETCH_WIDTH,
  parameter int unsigned DEPTH    = FETCH_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push_valid,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   push_ready,
  output logic                   pop_valid,
  output logic [WIDTH-1:0]       pop_data,
  input  logic                   pop_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [CW-1:0] AfLevel   = CW'(AF_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push_fire, pop_fire;

  // Handshakes look only at registered state, so a full FIFO refuses even when a pop fires.
  assign push_ready  = (count_q != FullCount);
  assign pop_valid   = (count_q != '0);
  assign count       = count_q;
  assign almost_full = (count_q >= AfLevel);
  assign overflow    = overflow_q;

  assign push_fire = push_valid & push_ready & ~flush;
  assign pop_fire  = pop_valid & pop_ready & ~flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_valid & ~push_ready & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fetch_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push_fire),
    .waddr(wr_ptr_q),
    .wdata(push_data),
    .raddr(rd_ptr_q),
    .rdata(pop_data)
  );

endmodule

// File: tb/tb_fetch_fifo.sv
// Directed bench for fetch_fifo: table-driven fill/drain/wrap plus hand-written corner sequences.
module tb_fetch_fifo;
  import fetch_pkg::*;

  localparam int W = FETCH_WIDTH;
  localparam int D = FETCH_DEPTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         push_valid = 1'b0;
  logic [W-1:0] push_data = '0;
  logic         push_ready;
  logic         pop_valid;
  logic [W-1:0] pop_data;
  logic         pop_ready = 1'b0;
  logic [$clog2(D):0] count;
  logic         almost_full;
  logic         overflow;

  int n_vec = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        fl;
    logic        pv;
    logic [15:0] pd;
    logic        pr;
    int          cnt;
    logic        chk;
    logic [15:0] data;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  fetch_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (pop_ready),
    .count      (count),
    .almost_full(almost_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Expected flags follow from the expected occupancy: full at D, almost full at D-2.
  task automatic check_state(input string tag, input int cnt, input logic chk,
                             input logic [15:0] data, input logic ovf);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".push_ready"}, 32'(push_ready), 32'(cnt != D));
    check({tag, ".pop_valid"}, 32'(pop_valid), 32'(cnt != 0));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(cnt >= D - 2));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    if (chk) check({tag, ".pop_data"}, 32'(pop_data), 32'(data));
  endtask

  task automatic step(input logic fl, input logic pv, input logic [15:0] pd, input logic pr);
    @(negedge clk);
    flush = fl;
    push_valid = pv;
    push_data = pd;
    pop_ready = pr;
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  task automatic add(input logic fl, input logic pv, input logic [15:0] pd, input logic pr,
                     input int cnt, input logic chk, input logic [15:0] data, input logic ovf);
    vec_t v;
    v.fl = fl; v.pv = pv; v.pd = pd; v.pr = pr;
    v.cnt = cnt; v.chk = chk; v.data = data; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    #2;
    check_state("reset", 0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 1..8, drain; then 6 in / 6 out so the A000 burst straddles the pointer wrap.
    for (int i = 0; i < 8; i++) add(0, 1, 16'(i + 1), 0, i + 1, 1, 16'h0001, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 16'h0, 1, 7 - i, (7 - i) != 0, 16'(i + 2), 0);
    for (int i = 0; i < 6; i++) add(0, 1, 16'(16'h0100 + i), 0, i + 1, 1, 16'h0100, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 16'h0, 1, 5 - i, (5 - i) != 0, 16'(16'h0101 + i), 0);
    for (int i = 0; i < 6; i++) add(0, 1, 16'(16'hA000 + i), 0, i + 1, 1, 16'hA000, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 16'h0, 1, 5 - i, (5 - i) != 0, 16'(16'hA001 + i), 0);

    foreach (vecs[i]) begin
      step(vecs[i].fl, vecs[i].pv, vecs[i].pd, vecs[i].pr);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].chk, vecs[i].data, vecs[i].ovf);
    end

    // Concurrent push+pop at count 4.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'(16'hC000 + i), 0);
      check_state("conc_fill", i + 1, 1, 16'hC000, 0);
    end
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 16'(16'hC004 + k), 1);
      check_state($sformatf("conc%0d", k), 4, 1, 16'(16'hC001 + k), 0);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 16'h0, 1);
      check_state("conc_drain", 3 - k, (3 - k) != 0, 16'(16'hC00B + k), 0);
    end

    // Full boundary: push refused while a pop fires.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 16'(16'hD000 + i), 0);
      check_state("full_fill", i + 1, 1, 16'hD000, 0);
    end
    step(0, 1, 16'hBEEF, 1);
    check_state("full_push_pop", 7, 1, 16'hD001, 1);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 16'h0, 1);
      check_state("full_drain", 6 - k, (6 - k) != 0, 16'(16'hD002 + k), 1);
    end

    // Flush suppresses the concurrent push and pop and keeps overflow.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 16'(16'hE000 + i), 0);
      check_state("flush_fill", i + 1, 1, 16'hE000, 1);
    end
    step(1, 1, 16'h5555, 1);
    check_state("flush", 0, 0, 16'h0, 1);
    step(0, 1, 16'h1234, 0);
    check_state("post_flush_push", 1, 1, 16'h1234, 1);
    step(0, 0, 16'h0, 1);
    check_state("post_flush_pop", 0, 0, 16'h0, 1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'(16'h7000 + i), 0);
      check_state("areset_fill", i + 1, 1, 16'h7000, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_state("areset", 0, 0, 16'h0, 0);
    @(negedge clk);
    push_valid = 1'b0;
    pop_ready = 1'b0;
    rst_n = 1'b1;
    step(0, 1, 16'h7777, 0);
    check_state("post_reset_push", 1, 1, 16'h7777, 0);
    step(0, 0, 16'h0, 1);
    check_state("post_reset_pop", 0, 0, 16'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
